// File: rtl/lsram_mem_wbuf.sv
// One-entry posted-write buffer between the AHB LSRAM interface and a single-port LSRAM.
// Writes drain when the RAM port is idle, and read data is merged with the buffered bytes.
module lsram_mem_wbuf #(
  parameter int MEM_AWIDTH = 9,
  parameter int RD_LAT     = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  mem_ren,
  input  logic                  mem_wen,
  input  logic [MEM_AWIDTH-1:0] mem_addr,
  input  logic [3:0]            mem_byteen,
  input  logic [31:0]           mem_wdata,
  output logic [31:0]           mem_rdata,
  output logic                  mem_rvalid,
  output logic                  ram_ren,
  output logic                  ram_wen,
  output logic [MEM_AWIDTH-1:0] ram_addr,
  output logic [3:0]            ram_ben,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  output logic                  wbuf_empty,
  output logic                  collision
);

  logic                  buf_vld;
  logic                  buf_vld_nxt;
  logic [MEM_AWIDTH-1:0] buf_addr;
  logic [3:0]            buf_ben;
  logic [31:0]           buf_data;

  logic                  rd_issue;
  logic                  commit;
  logic                  snap_hit;

  logic                  vld_p  [RD_LAT];
  logic                  hit_p  [RD_LAT];
  logic [3:0]            ben_p  [RD_LAT];
  logic [31:0]           data_p [RD_LAT];

  function automatic logic [31:0] merge_bytes(input logic        hit,
                                              input logic [3:0]  ben,
                                              input logic [31:0] snap,
                                              input logic [31:0] ram);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = (hit && ben[i]) ? snap[8*i +: 8] : ram[8*i +: 8];
    return res;
  endfunction

  // A simultaneous read+write is treated as a write; the read is dropped.
  assign rd_issue = mem_ren & ~mem_wen;
  assign commit   = buf_vld & (mem_wen | ~mem_ren);
  assign snap_hit = buf_vld && (buf_addr == mem_addr);

  always_comb begin
    buf_vld_nxt = buf_vld;
    if (mem_wen)
      buf_vld_nxt = 1'b1;
    else if (!mem_ren)
      buf_vld_nxt = 1'b0;
  end

  // RAM port: combinational, forced idle while reset is asserted
  always_comb begin
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_ben   = '0;
    ram_wdata = '0;
    if (HRESETN) begin
      if (commit) begin
        ram_wen   = 1'b1;
        ram_addr  = buf_addr;
        ram_ben   = buf_ben;
        ram_wdata = buf_data;
      end else if (rd_issue) begin
        ram_ren  = 1'b1;
        ram_addr = mem_addr;
      end
    end
  end

  // Buffer and status control
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      buf_vld    <= 1'b0;
      wbuf_empty <= 1'b1;
      collision  <= 1'b0;
    end else begin
      buf_vld    <= buf_vld_nxt;
      wbuf_empty <= ~buf_vld_nxt;
      collision  <= collision | (mem_ren & mem_wen);
    end
  end

  always_ff @(posedge HCLK) begin
    if (mem_wen) begin
      buf_addr <= mem_addr;
      buf_ben  <= mem_byteen;
      buf_data <= mem_wdata;
    end
  end

  // Read pipeline stage p0..p(RD_LAT-1): snapshot travels with the RAM access
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      for (int i = 0; i < RD_LAT; i++)
        vld_p[i] <= 1'b0;
    end else begin
      vld_p[0] <= rd_issue;
      for (int i = 1; i < RD_LAT; i++)
        vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge HCLK) begin
    hit_p[0]  <= snap_hit;
    ben_p[0]  <= buf_ben;
    data_p[0] <= buf_data;
    for (int i = 1; i < RD_LAT; i++) begin
      hit_p[i]  <= hit_p[i-1];
      ben_p[i]  <= ben_p[i-1];
      data_p[i] <= data_p[i-1];
    end
  end

  // Return stage: ram_rdata is valid while the last pipeline stage is occupied
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
    end else begin
      mem_rvalid <= vld_p[RD_LAT-1];
      if (vld_p[RD_LAT-1])
        mem_rdata <= merge_bytes(hit_p[RD_LAT-1], ben_p[RD_LAT-1],
                                 data_p[RD_LAT-1], ram_rdata);
    end
  end

endmodule

// File: tb/tb_lsram_mem_wbuf.sv
// Bench for lsram_mem_wbuf: emulates the physical RAM and checks every cycle against a
// logical-memory model (latest-write semantics, FIFO of pending commits, read return queue).
module tb_lsram_mem_wbuf;
  localparam int AW  = 9;
  localparam int LAT = 2;

  logic          HCLK, HRESETN;
  logic          mem_ren, mem_wen;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_byteen;
  logic [31:0]   mem_wdata, mem_rdata;
  logic          mem_rvalid;
  logic          ram_ren, ram_wen;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_ben;
  logic [31:0]   ram_wdata, ram_rdata;
  logic          wbuf_empty, collision;

  lsram_mem_wbuf #(.MEM_AWIDTH(AW), .RD_LAT(LAT)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_byteen(mem_byteen), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_ben(ram_ben), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .wbuf_empty(wbuf_empty), .collision(collision)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Physical RAM emulation
  logic [31:0] ram [1<<AW];
  logic [31:0] rd_pipe [LAT];
  logic        pre_done = 1'b0;
  assign ram_rdata = rd_pipe[LAT-1];

  always @(posedge HCLK) begin
    if (!pre_done) begin
      for (int i = 0; i < (1<<AW); i++) ram[i] <= 32'hC0DE0000 | i;
      ram[9'h020] <= 32'h11223344;
      pre_done <= 1'b1;
    end else if (ram_wen) begin
      for (int b = 0; b < 4; b++)
        if (ram_ben[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    rd_pipe[0] <= ram_ren ? ram[ram_addr] : 32'hxxxx_xxxx;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  // Behavioural model
  typedef struct { logic [AW-1:0] addr; logic [3:0] ben; logic [31:0] data; } wr_t;
  typedef struct { int due; logic [31:0] data; } rd_t;
  wr_t         wq[$];
  rd_t         rq[$];
  logic [31:0] lmem [1<<AW];
  logic        exp_coll;
  logic [31:0] last_rd;

  initial begin
    logic exp_rv, exp_cm;
    wr_t  w;
    rd_t  r;
    forever begin
      @(negedge HCLK);
      if (!HRESETN) begin
        wq.delete();
        rq.delete();
        exp_coll = 1'b0;
        last_rd  = '0;
        for (int i = 0; i < (1<<AW); i++) lmem[i] = ram[i];
      end else begin
        exp_rv = (rq.size() > 0) && (rq[0].due == cyc);
        chk("rvalid", mem_rvalid, exp_rv);
        if (exp_rv) begin
          last_rd = rq[0].data;
          void'(rq.pop_front());
        end
        chk("rdata", mem_rdata, last_rd);
        chk("wbuf_empty", wbuf_empty, wq.size() == 0);
        chk("collision", collision, exp_coll);
        exp_cm = (wq.size() > 0) && (mem_wen || !mem_ren);
        chk("ram_wen", ram_wen, exp_cm);
        chk("ram_ren", ram_ren, mem_ren && !mem_wen);
        if (exp_cm) begin
          chk("commit_addr", ram_addr, wq[0].addr);
          chk("commit_ben", ram_ben, wq[0].ben);
          chk("commit_data", ram_wdata, wq[0].data);
          void'(wq.pop_front());
        end else if (mem_ren && !mem_wen) begin
          chk("read_addr", ram_addr, mem_addr);
        end
        if (mem_wen) begin
          w.addr = mem_addr; w.ben = mem_byteen; w.data = mem_wdata;
          wq.push_back(w);
          for (int b = 0; b < 4; b++)
            if (mem_byteen[b]) lmem[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
          if (mem_ren) exp_coll = 1'b1;
        end else if (mem_ren) begin
          r.due = cyc + LAT + 1; r.data = lmem[mem_addr];
          rq.push_back(r);
        end
      end
      cyc++;
    end
  end

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic drv(input logic r, input logic w, input logic [AW-1:0] a,
                     input logic [3:0] b, input logic [31:0] d);
    mem_ren = r; mem_wen = w; mem_addr = a; mem_byteen = b; mem_wdata = d;
  endtask

  task automatic idle;
    drv(1'b0, 1'b0, '0, 4'h0, 32'h0);
  endtask

  initial begin
    HRESETN = 1'b0;
    drv(1'b1, 1'b0, 9'h033, 4'h0, 32'h0);
    repeat (3) tick;
    #3;
    chk("rst_wbuf_empty", wbuf_empty, 1'b1);
    chk("rst_collision", collision, 1'b0);
    chk("rst_rvalid", mem_rvalid, 1'b0);
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_ram_ren", ram_ren, 1'b0);
    chk("rst_ram_addr", ram_addr, 9'h0);
    idle;
    @(negedge HCLK); #2;
    HRESETN = 1'b1;
    tick;

    // Posted write then drain on an idle cycle
    drv(1'b0, 1'b1, 9'h010, 4'hF, 32'hDEADBEEF);
    #3 chk("t1_wen_c1", ram_wen, 1'b0);
    tick; idle;
    #3;
    chk("t1_empty_c2", wbuf_empty, 1'b0);
    chk("t1_wen_c2", ram_wen, 1'b1);
    chk("t1_addr_c2", ram_addr, 9'h010);
    chk("t1_data_c2", ram_wdata, 32'hDEADBEEF);
    tick;
    #3 chk("t1_empty_c3", wbuf_empty, 1'b1);
    tick;

    // Partial write forwarded into the following read
    drv(1'b0, 1'b1, 9'h020, 4'b0101, 32'hAABBCCDD);
    tick;
    drv(1'b1, 1'b0, 9'h020, 4'h0, 32'h0);
    tick; idle;
    tick; tick;
    #3;
    chk("t2_rvalid", mem_rvalid, 1'b1);
    chk("t2_rdata", mem_rdata, 32'h11BB33DD);
    chk("t2_ram", ram[9'h020], 32'h11BB33DD);
    tick;

    // Back-to-back reads
    for (int k = 0; k < 7; k++) begin
      if (k < 4) drv(1'b1, 1'b0, 9'(1 + k), 4'h0, 32'h0);
      else idle;
      #3;
      chk("t3_no_wen", ram_wen, 1'b0);
      if (k >= 3) begin
        chk("t3_rvalid", mem_rvalid, 1'b1);
        chk("t3_rdata", mem_rdata, 32'hC0DE0000 | (k - 2));
      end else begin
        chk("t3_rvalid_lo", mem_rvalid, 1'b0);
      end
      tick;
    end

    // Two writes back to back: first commits under the second
    drv(1'b0, 1'b1, 9'h005, 4'hF, 32'h55550005);
    tick;
    drv(1'b0, 1'b1, 9'h006, 4'hF, 32'h66660006);
    #3;
    chk("t4_wen_a", ram_wen, 1'b1);
    chk("t4_addr_a", ram_addr, 9'h005);
    tick; idle;
    #3;
    chk("t4_wen_b", ram_wen, 1'b1);
    chk("t4_addr_b", ram_addr, 9'h006);
    chk("t4_data_b", ram_wdata, 32'h66660006);
    tick;
    chk("t4_ram_a", ram[9'h005], 32'h55550005);
    chk("t4_ram_b", ram[9'h006], 32'h66660006);

    // Same-address writes are not coalesced; read merges RAM with newest entry
    drv(1'b0, 1'b1, 9'h040, 4'b0001, 32'h000000EE);
    tick;
    drv(1'b0, 1'b1, 9'h040, 4'b1000, 32'h77000000);
    tick;
    drv(1'b1, 1'b0, 9'h040, 4'h0, 32'h0);
    tick; idle;
    tick; tick;
    #3 chk("t5_merge", mem_rdata, 32'h77DE00EE);
    tick;

    // A write accepted after the read issue is not visible to it
    drv(1'b1, 1'b0, 9'h050, 4'h0, 32'h0);
    tick;
    drv(1'b0, 1'b1, 9'h050, 4'hF, 32'hFFFFFFFF);
    tick; idle;
    tick;
    #3 chk("t6_old", mem_rdata, 32'hC0DE0050);
    tick;
    drv(1'b1, 1'b0, 9'h050, 4'h0, 32'h0);
    tick; idle;
    repeat (3) tick;

    // Simultaneous read and write
    drv(1'b1, 1'b1, 9'h007, 4'hF, 32'h77777777);
    #3 chk("t7_ren", ram_ren, 1'b0);
    tick; idle;
    #3;
    chk("t7_coll", collision, 1'b1);
    chk("t7_buffered", wbuf_empty, 1'b0);
    repeat (5) tick;
    chk("t7_coll_hold", collision, 1'b1);
    chk("t7_ram", ram[9'h007], 32'h77777777);

    // Reset with a pending write and a read in flight
    drv(1'b0, 1'b1, 9'h060, 4'hF, 32'h12345678);
    tick;
    drv(1'b1, 1'b0, 9'h061, 4'h0, 32'h0);
    tick; idle;
    #2 HRESETN = 1'b0;
    #1;
    chk("t8_empty", wbuf_empty, 1'b1);
    chk("t8_coll", collision, 1'b0);
    chk("t8_rvalid", mem_rvalid, 1'b0);
    chk("t8_rdata", mem_rdata, 32'h0);
    chk("t8_wen", ram_wen, 1'b0);
    @(posedge HCLK);
    @(negedge HCLK); #2;
    HRESETN = 1'b1;
    repeat (6) tick;
    chk("t8_ram", ram[9'h060], 32'hC0DE0060);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
